bram_req_ctrl: RTL
==================

BRAM_REQ_CTRL -- requirements
Module: bram_req_ctrl

Interface
REQ-001 SHALL have parameter INNER_WIDTH, default 32: data word width in bits, a multiple of 8.
REQ-002 SHALL have parameter OUTER_WIDTH, default 32: BRAM depth in words.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock, with all state on posedge.
REQ-004 SHALL have port RST, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port rd_req_valid, input, 1 bit: upstream read request valid.
REQ-006 SHALL have port rd_req_ready, output, 1 bit: read request accepted when valid&&ready.
REQ-007 SHALL have port rd_req_index, input, $clog2(OUTER_WIDTH) bits: read word index.
REQ-008 SHALL have port rd_resp_valid, output, 1 bit: read response valid.
REQ-009 SHALL have port rd_resp_ready, input, 1 bit: downstream takes the response when valid&&ready.
REQ-010 SHALL have port rd_resp_data, output, INNER_WIDTH bits: read response data.
REQ-011 SHALL have port wr_req_valid, input, 1 bit: write request.
REQ-012 SHALL have port wr_req_byte_en, input, INNER_WIDTH/8 bits: write byte enables.
REQ-013 SHALL have port wr_req_index, input, $clog2(OUTER_WIDTH) bits: write word index.
REQ-014 SHALL have port wr_req_data, input, INNER_WIDTH bits: write data.
REQ-015 SHALL have port bram_ren, output, 1 bit: BRAM read-port-0 enable.
REQ-016 SHALL have port bram_rindex, output, $clog2(OUTER_WIDTH) bits: BRAM read-port-0 index.
REQ-017 SHALL have port bram_rdata, input, INNER_WIDTH bits: BRAM read-port-0 data, valid 1 cycle after ren.
REQ-018 SHALL have port bram_wen_byte, output, INNER_WIDTH/8 bits: BRAM byte write enables.
REQ-019 SHALL have port bram_windex, output, $clog2(OUTER_WIDTH) bits: BRAM write index.
REQ-020 SHALL have port bram_wdata, output, INNER_WIDTH bits: BRAM write data.

Function
REQ-021 SHALL drive the write path combinationally and always accept writes: bram_wen_byte = wr_req_valid ? wr_req_byte_en : 0; bram_windex/bram_wdata pass through.
REQ-022 SHALL drive bram_ren = rd_req_valid && rd_req_ready and bram_rindex = rd_req_index in the same cycle.
REQ-023 SHALL set an inflight flag in the cycle after each accepted read; bram_rdata is sampled only while inflight=1.
REQ-024 SHALL, when a write is accepted in the same cycle as a read to the same index, register a merge mask (wr_req_byte_en) and merge data, because the BRAM returns pre-write data.
REQ-025 SHALL merge inflight data per byte: the byte comes from merge data where the mask bit is 1, else from bram_rdata; with no collision the mask is 0.
REQ-026 SHALL hold responses in a 2-entry in-order response FIFO with a head pointer, a tail pointer (1 bit each, wrapping) and count 0..2.
REQ-027 SHALL compute rd_resp_valid = (count!=0) || inflight, with rd_resp_data = FIFO head if count!=0, else the merged inflight data (bypass, 1-cycle latency).
REQ-028 SHALL push the merged inflight data into the FIFO when inflight=1 and it is not consumed in that cycle by bypass.
REQ-029 SHALL pop the FIFO head on rd_resp_valid && rd_resp_ready && count!=0, and allow push and pop in the same cycle.
REQ-030 SHALL compute rd_req_ready = (count + inflight) < 2 from registered state only, with no path from rd_resp_ready.
REQ-031 SHALL keep responses in request order, with no loss or duplication under any rd_resp_ready pattern.
REQ-032 SHALL not use BRAM read port 1; the integrating parent ties it off.

Reset
REQ-033 SHALL, when RST=1, asynchronously clear inflight, count, pointers and merge mask.
REQ-034 SHALL hold the following during reset: rd_resp_valid=0, rd_req_ready=1, and bram_ren=0 and bram_wen_byte=0 while request inputs are low.
REQ-035 SHALL discard inflight or buffered responses on reset mid-operation; none appear after release.

Verification
REQ-036 SHALL cover reset: RST=1 -> rd_resp_valid=0, rd_req_ready=1, bram_ren=0, bram_wen_byte=0.
REQ-037 SHALL cover write then read: write 0xA5A5A5A5 to idx 3 (byte_en 4'b1111); next cycle read idx 3, resp_ready=1 -> rd_resp_valid 1 cycle after accept, data 0xA5A5A5A5.
REQ-038 SHALL cover same-cycle RAW: idx 5 holds 0x11223344; read idx 5 + write idx 5, byte_en 4'b0011, data 0xAABBCCDD -> response 0x1122CCDD.
REQ-039 SHALL cover backpressure: resp_ready=0, reads idx 1,2,3 back-to-back -> only idx 1,2 accepted, then rd_req_ready=0; resp_ready=1 -> idx 1 then 2 data in order, then idx 3 accepted.
REQ-040 SHALL cover streaming: 32 consecutive reads idx 0..31, resp_ready=1 -> one response per cycle, each 1 cycle after its request, in order.
REQ-041 SHALL cover reset mid-operation: count=1, inflight=1, pulse RST -> rd_resp_valid=0 immediately; after release no stale response, rd_req_ready=1.

Source files
------------

// File: rtl/bram_req_ctrl.sv
// Read/write request front-end for a single-port-read BRAM with a 2-entry response FIFO.
// Reads that collide with a same-cycle write get the written bytes merged into the response.
module bram_req_ctrl #(
    parameter int INNER_WIDTH = 32,
    parameter int OUTER_WIDTH = 32
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           rd_req_valid,
    output logic                           rd_req_ready,
    input  logic [$clog2(OUTER_WIDTH)-1:0] rd_req_index,
    output logic                           rd_resp_valid,
    input  logic                           rd_resp_ready,
    output logic [INNER_WIDTH-1:0]         rd_resp_data,
    input  logic                           wr_req_valid,
    input  logic [INNER_WIDTH/8-1:0]       wr_req_byte_en,
    input  logic [$clog2(OUTER_WIDTH)-1:0] wr_req_index,
    input  logic [INNER_WIDTH-1:0]         wr_req_data,
    output logic                           bram_ren,
    output logic [$clog2(OUTER_WIDTH)-1:0] bram_rindex,
    input  logic [INNER_WIDTH-1:0]         bram_rdata,
    output logic [INNER_WIDTH/8-1:0]       bram_wen_byte,
    output logic [$clog2(OUTER_WIDTH)-1:0] bram_windex,
    output logic [INNER_WIDTH-1:0]         bram_wdata
);

    localparam int BW = INNER_WIDTH / 8;

    logic                   inflight;
    logic [1:0]             count;
    logic                   head;
    logic                   tail;
    logic [BW-1:0]          merge_mask;
    logic [INNER_WIDTH-1:0] merge_data;
    logic [INNER_WIDTH-1:0] fifo_mem [2];

    logic                   collide;
    logic                   head_valid;
    logic                   bypass;
    logic                   push;
    logic                   pop;
    logic [1:0]             occupancy;
    logic [INNER_WIDTH-1:0] merged_data;

    assign bram_wen_byte = wr_req_valid ? wr_req_byte_en : '0;
    assign bram_windex   = wr_req_index;
    assign bram_wdata    = wr_req_data;

    // Occupancy counts the slot an inflight read will need, so ready never depends on rd_resp_ready.
    assign occupancy    = count + {1'b0, inflight};
    assign rd_req_ready = (occupancy < 2'd2);
    assign bram_ren     = rd_req_valid && rd_req_ready;
    assign bram_rindex  = rd_req_index;

    assign collide = bram_ren && wr_req_valid && (wr_req_index == rd_req_index);

    always_comb begin
        merged_data = bram_rdata;
        for (int b = 0; b < BW; b++) begin
            if (merge_mask[b]) begin
                merged_data[b*8 +: 8] = merge_data[b*8 +: 8];
            end
        end
    end

    assign head_valid    = (count != 2'd0);
    assign rd_resp_valid = head_valid || inflight;
    assign rd_resp_data  = head_valid ? fifo_mem[head] : merged_data;

    assign bypass = inflight && !head_valid && rd_resp_ready;
    assign push   = inflight && !bypass;
    assign pop    = head_valid && rd_resp_ready;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            inflight   <= 1'b0;
            count      <= 2'd0;
            head       <= 1'b0;
            tail       <= 1'b0;
            merge_mask <= '0;
        end else begin
            inflight <= bram_ren;
            if (bram_ren) begin
                merge_mask <= collide ? wr_req_byte_en : '0;
            end
            if (push) begin
                tail <= ~tail;
            end
            if (pop) begin
                head <= ~head;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Data-only storage; validity is tracked entirely by the reset control above.
    always_ff @(posedge CLK) begin
        if (bram_ren) begin
            merge_data <= wr_req_data;
        end
        if (push) begin
            fifo_mem[tail] <= merged_data;
        end
    end

endmodule
